// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory arbiter slice: the arbiter state
// encoding and the fixed MIPS segment constants used for kseg0/kseg1
// address translation.
package mem_arb_pkg;

    // Arbiter states: the data port has its own request/wait pair, and so
    // does the fetch port. The state itself records whose transaction is
    // on the bus.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DREQ  = 3'd1,
        ST_DWAIT = 3'd2,
        ST_IREQ  = 3'd3,
        ST_IWAIT = 3'd4
    } arb_state_t;

    // kseg0 starts here, and kseg1 ends just below KSEG2_BASE.
    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

    // Clearing bits [31:29] maps kseg0/kseg1 onto the physical low 512 MB.
    localparam logic [31:0] PHYS_MASK  = 32'h1FFF_FFFF;

endpackage

// File: rtl/addr_xlate.sv
// addr_xlate
// Combinational fixed-mapping translator. Addresses in kseg0/kseg1
// (0x8000_0000 - 0xBFFF_FFFF) have bits [31:29] cleared. All other
// addresses pass through unchanged. When XLATE is 0, every address passes
// through.
//
// Ports:
//   vaddr  in  32  virtual address from the core
//   paddr  out 32  physical address presented to the bus
module addr_xlate
    import mem_arb_pkg::*;
#(
    parameter bit XLATE = 1'b1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    // Only the unmapped kernel segments are translated. kuseg and kseg2/3
    // are left untouched because this core has no TLB.
    always_comb begin
        paddr = vaddr;
        if (XLATE && (vaddr >= KSEG0_BASE) && (vaddr < KSEG2_BASE)) begin
            paddr = vaddr & PHYS_MASK;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Merges the core's instruction-fetch port and data-memory port onto a
// single-outstanding request/response bus. It raises i_stall/d_stall
// while an access is incomplete, and it holds completed results (with
// done flags) while the pipeline is frozen. The data port has priority,
// and a transaction is never preempted once it has left IDLE.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_en/inst_addr            fetch request from the core
//   inst_rdata, i_stall          registered fetch result, fetch stall
//   data_en/sel/addr/wdata       data access (sel == 0 means read)
//   data_rdata, d_stall          registered load result, data stall
//   longest_stall                core pipeline frozen
//   bus_req/wr/strb/addr/wdata   request towards the bus bridge
//   bus_addr_ok, bus_data_ok     request accepted, response/ack
//   bus_rdata                    read data, valid with bus_data_ok
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit XLATE = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_en,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        i_stall,
    input  logic        data_en,
    input  logic [3:0]  data_sel,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        d_stall,
    input  logic        longest_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_strb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_t  state_q, state_d;
    logic        bus_wr_q, bus_wr_d;
    logic [3:0]  bus_strb_q, bus_strb_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;

    logic        d_pend, i_pend;
    logic        i_done_set, d_done_set;
    logic [31:0] sel_addr, phys_addr;

    // A port is pending only if its current access has not already been
    // served during this (possibly frozen) pipeline cycle.
    assign d_pend = data_en & ~d_done_q;
    assign i_pend = inst_en & ~i_done_q;

    // One translator is shared by both ports. It sees whichever address
    // the IDLE decision would latch.
    assign sel_addr = d_pend ? data_addr : inst_addr;

    addr_xlate #(
        .XLATE (XLATE)
    ) u_addr_xlate (
        .vaddr (sel_addr),
        .paddr (phys_addr)
    );

    // Next-state logic. The request fields are latched only in IDLE, so
    // they stay stable on the bus until accepted, whatever the core does.
    // Completion can come in xREQ (same-cycle addr_ok/data_ok) or in xWAIT.
    always_comb begin
        state_d      = state_q;
        bus_wr_d     = bus_wr_q;
        bus_strb_d   = bus_strb_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        i_done_set   = 1'b0;
        d_done_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_pend) begin
                    state_d     = ST_DREQ;
                    bus_wr_d    = |data_sel;
                    bus_strb_d  = data_sel;
                    bus_addr_d  = phys_addr;
                    bus_wdata_d = data_wdata;
                end else if (i_pend) begin
                    state_d     = ST_IREQ;
                    bus_wr_d    = 1'b0;
                    bus_strb_d  = 4'b0000;
                    bus_addr_d  = phys_addr;
                    bus_wdata_d = 32'h0;
                end
            end
            ST_DREQ, ST_DWAIT: begin
                if ((state_q == ST_DWAIT || bus_addr_ok) && bus_data_ok) begin
                    state_d    = ST_IDLE;
                    d_done_set = 1'b1;
                    if (!bus_wr_q) begin
                        data_rdata_d = bus_rdata;
                    end
                end else if (state_q == ST_DREQ && bus_addr_ok) begin
                    state_d = ST_DWAIT;
                end
            end
            ST_IREQ, ST_IWAIT: begin
                if ((state_q == ST_IWAIT || bus_addr_ok) && bus_data_ok) begin
                    state_d      = ST_IDLE;
                    i_done_set   = 1'b1;
                    inst_rdata_d = bus_rdata;
                end else if (state_q == ST_IREQ && bus_addr_ok) begin
                    state_d = ST_IWAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completion must survive the same edge at which the pipeline
        // advances, so setting a done flag wins over clearing it.
        i_done_d = i_done_set | (i_done_q & longest_stall);
        d_done_d = d_done_set | (d_done_q & longest_stall);
    end

    // State and datapath registers. Reset abandons any transaction that is
    // in flight, and no bus completion for it is expected afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            bus_wr_q     <= 1'b0;
            bus_strb_q   <= 4'b0000;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_wr_q     <= bus_wr_d;
            bus_strb_q   <= bus_strb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
        end
    end

    // The stalls depend only on registers and core inputs. There is no path
    // from the bus inputs, which keeps the core's stall timing short.
    assign i_stall    = inst_en & ~i_done_q;
    assign d_stall    = data_en & ~d_done_q;

    assign bus_req    = (state_q == ST_DREQ) || (state_q == ST_IREQ);
    assign bus_wr     = bus_wr_q;
    assign bus_strb   = bus_strb_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. The core's longest_stall is modelled as
// the OR of both stall outputs, which is how the real core freezes. The
// bus side is driven cycle by cycle with hand-computed responses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_en = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_en = 1'b0;
    logic [3:0]  data_sel = 4'b0000;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_strb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int checkCount = 0;
    int failCount  = 0;

    // The core stays frozen for as long as either memory port is stalled.
    assign longest_stall = i_stall | d_stall;

    always #5 clk = ~clk;

    mem_arbiter #(
        .XLATE (1'b1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .inst_en       (inst_en),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .i_stall       (i_stall),
        .data_en       (data_en),
        .data_sel      (data_sel),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .bus_req       (bus_req),
        .bus_wr        (bus_wr),
        .bus_strb      (bus_strb),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_addr_ok   (bus_addr_ok),
        .bus_data_ok   (bus_data_ok),
        .bus_rdata     (bus_rdata)
    );

    // Moves to 1 time unit after the next rising edge. The bench drives its
    // inputs there, so they settle well before the following edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives this cycle's bus response and lets combinational outputs settle.
    task automatic applyStimulus(input logic addrOk, input logic dataOk,
                                 input logic [31:0] rdata);
        bus_addr_ok = addrOk;
        bus_data_ok = dataOk;
        bus_rdata   = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("rst_bus_req", {31'h0, bus_req}, 32'h0);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        checkOutput("rst_bus_wr", {28'h0, bus_strb[3:1], bus_wr}, 32'h0);
        checkOutput("rst_inst_rdata", inst_rdata, 32'h0);
        checkOutput("rst_data_rdata", data_rdata, 32'h0);
        checkOutput("rst_i_stall", {31'h0, i_stall}, 32'h0);
        nextCycle();
        nextCycle();
        resetn = 1'b1;
        nextCycle();

        // Fetch only, with minimum latency: C0 to C3.
        $display("[TB] fetch only");
        inst_en = 1'b1; inst_addr = 32'hBFC0_0000;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("f_c0_i_stall", {31'h0, i_stall}, 32'h1);
        checkOutput("f_c0_bus_req", {31'h0, bus_req}, 32'h0);
        nextCycle();
        checkOutput("f_c1_bus_req", {31'h0, bus_req}, 32'h1);
        checkOutput("f_c1_bus_addr", bus_addr, 32'h1FC0_0000);
        checkOutput("f_c1_bus_wr", {31'h0, bus_wr}, 32'h0);
        checkOutput("f_c1_bus_strb", {28'h0, bus_strb}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h2408_0001);
        checkOutput("f_c2_bus_req", {31'h0, bus_req}, 32'h0);
        checkOutput("f_c2_i_stall", {31'h0, i_stall}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("f_c3_i_stall", {31'h0, i_stall}, 32'h0);
        checkOutput("f_c3_inst_rdata", inst_rdata, 32'h2408_0001);
        inst_en = 1'b0;
        nextCycle();

        // Simultaneous requests: data first, with same-cycle ack.
        $display("[TB] simultaneous fetch and load");
        inst_en = 1'b1; inst_addr = 32'hBFC0_0004;
        data_en = 1'b1; data_sel = 4'b0000; data_addr = 32'h8000_0010;
        nextCycle();
        checkOutput("s_d_bus_req", {31'h0, bus_req}, 32'h1);
        checkOutput("s_d_bus_addr", bus_addr, 32'h0000_0010);
        checkOutput("s_d_bus_wr", {31'h0, bus_wr}, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'hCAFE_0001);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("s_d_stall", {31'h0, d_stall}, 32'h0);
        checkOutput("s_i_stall_held", {31'h0, i_stall}, 32'h1);
        checkOutput("s_data_rdata", data_rdata, 32'hCAFE_0001);
        nextCycle();
        checkOutput("s_i_bus_req", {31'h0, bus_req}, 32'h1);
        checkOutput("s_i_bus_addr", bus_addr, 32'h1FC0_0004);
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h3C1D_0000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("s_i_stall", {31'h0, i_stall}, 32'h0);
        checkOutput("s_inst_rdata", inst_rdata, 32'h3C1D_0000);
        inst_en = 1'b0; data_en = 1'b0;
        nextCycle();

        // Store: write strobes and data, load result untouched.
        $display("[TB] store");
        data_en = 1'b1; data_sel = 4'b0011; data_addr = 32'hA000_1000;
        data_wdata = 32'h1234_ABCD;
        nextCycle();
        checkOutput("w_bus_wr", {31'h0, bus_wr}, 32'h1);
        checkOutput("w_bus_strb", {28'h0, bus_strb}, 32'h3);
        checkOutput("w_bus_addr", bus_addr, 32'h0000_1000);
        checkOutput("w_bus_wdata", bus_wdata, 32'h1234_ABCD);
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("w_wait_d_stall", {31'h0, d_stall}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("w_d_stall", {31'h0, d_stall}, 32'h0);
        checkOutput("w_data_rdata", data_rdata, 32'hCAFE_0001);
        data_en = 1'b0; data_sel = 4'b0000;
        nextCycle();

        // Frozen pipeline: the fetch completes, but the data port then keeps the core stalled.
        $display("[TB] frozen pipeline");
        inst_en = 1'b1; inst_addr = 32'h0040_0000;
        nextCycle();
        checkOutput("z_i_bus_addr", bus_addr, 32'h0040_0000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        data_en = 1'b1; data_addr = 32'hC000_1000;
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h1111_2222);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("z_i_stall", {31'h0, i_stall}, 32'h0);
        checkOutput("z_inst_rdata", inst_rdata, 32'h1111_2222);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("z_hold_bus_addr%0d", i), bus_addr, 32'hC000_1000);
            checkOutput($sformatf("z_hold_bus_req%0d", i), {31'h0, bus_req}, 32'h1);
            checkOutput($sformatf("z_hold_i_stall%0d", i), {31'h0, i_stall}, 32'h0);
            checkOutput($sformatf("z_hold_inst_rdata%0d", i), inst_rdata, 32'h1111_2222);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 32'h3333_4444);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("z_d_stall", {31'h0, d_stall}, 32'h0);
        checkOutput("z_data_rdata", data_rdata, 32'h3333_4444);
        checkOutput("z_inst_rdata_end", inst_rdata, 32'h1111_2222);
        inst_en = 1'b0; data_en = 1'b0;
        nextCycle();

        // Exception flush: inst_en drops while the fetch is in IWAIT.
        $display("[TB] exception flush");
        inst_en = 1'b1; inst_addr = 32'h8000_0100;
        nextCycle();
        checkOutput("x_bus_addr", bus_addr, 32'h0000_0100);
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        inst_en = 1'b0;
        #1;
        checkOutput("x_i_stall", {31'h0, i_stall}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h5555_6666);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("x_bus_req", {31'h0, bus_req}, 32'h0);
        checkOutput("x_inst_rdata", inst_rdata, 32'h5555_6666);
        // A new load issuing after one cycle shows the arbiter is back in IDLE.
        data_en = 1'b1; data_sel = 4'b0000; data_addr = 32'h9000_0000;
        nextCycle();
        checkOutput("x_next_bus_req", {31'h0, bus_req}, 32'h1);
        checkOutput("x_next_bus_addr", bus_addr, 32'h1000_0000);

        // Async reset during DWAIT.
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("r_dwait_d_stall", {31'h0, d_stall}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("r_bus_req", {31'h0, bus_req}, 32'h0);
        checkOutput("r_bus_addr", bus_addr, 32'h0);
        checkOutput("r_inst_rdata", inst_rdata, 32'h0);
        checkOutput("r_data_rdata", data_rdata, 32'h0);
        checkOutput("r_d_stall", {31'h0, d_stall}, 32'h1);
        nextCycle();
        resetn = 1'b1;
        #1;
        checkOutput("r_post_bus_req", {31'h0, bus_req}, 32'h0);
        nextCycle();
        checkOutput("r_reissue_bus_req", {31'h0, bus_req}, 32'h1);
        checkOutput("r_reissue_bus_addr", bus_addr, 32'h1000_0000);
        data_en = 1'b0;
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the core's instruction-fetch and data-memory ports onto one shared single-outstanding request/response bus, which feeds the AXI bridge. It generates `i_stall`/`d_stall` back to the core and holds completed results while the pipeline is frozen. It applies fixed MIPS kseg0/kseg1 address translation. It sits between `mips` and the bus bridge inside the CPU top.

## Interface
Parameters:
- `XLATE`, 1: when 1, addresses 0x8000_0000–0xBFFF_FFFF have bits [31:29] cleared; all other addresses pass unchanged. When 0, no translation is applied.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_en`  in  1  fetch request valid; same as the core's `instr_enF`.
- `inst_addr`  in  32  fetch address (`pcF`).
- `inst_rdata`  out  32  fetched instruction, registered.
- `i_stall`  out  1  fetch not yet complete.
- `data_en`  in  1  data access valid (`mem_enM`).
- `data_sel`  in  4  byte strobes; 4'b0000 means read.
- `data_addr`  in  32  data address (`aluoutM`).
- `data_wdata`  in  32  store data.
- `data_rdata`  out  32  load result, registered.
- `d_stall`  out  1  data access not yet complete.
- `longest_stall`  in  1  core pipeline frozen.
- `bus_req`  out  1  bus request valid.
- `bus_wr`  out  1  1 for write.
- `bus_strb`  out  4  write strobes; 0 for reads.
- `bus_addr`  out  32  translated address.
- `bus_wdata`  out  32  write data.
- `bus_addr_ok`  in  1  request accepted.
- `bus_data_ok`  in  1  response or write acknowledge.
- `bus_rdata`  in  32  read data, valid with `bus_data_ok`.

## Operation
- States: IDLE, DREQ, DWAIT, IREQ, IWAIT.
- Pending flags:
  - `d_pend = data_en & ~d_done`
  - `i_pend = inst_en & ~i_done`
- IDLE:
  - If `d_pend`, latch the data request into the request registers and go to DREQ.
  - Else if `i_pend`, latch the fetch request and go to IREQ.
  - Data wins when both are pending. There is no preemption after leaving IDLE.
- xREQ:
  - `bus_req`=1, driven from the latched registers, so the request stays stable regardless of core inputs.
  - On `bus_addr_ok`, go to xWAIT.
  - If `bus_data_ok` arrives in the same cycle, complete immediately and go to IDLE.
- xWAIT:
  - On `bus_data_ok`, go to IDLE.
  - For reads, capture `bus_rdata` into `inst_rdata`/`data_rdata`.
  - Set `i_done`/`d_done`.
- An in-flight transaction always runs to completion, even if `inst_en`/`data_en` drop (exception flush). Its result is written and its done flag is set.
- Done flags:
  - Cleared at any edge where `longest_stall`=0, because the pipeline advanced.
  - Setting a done flag takes priority over clearing it.
- Stall outputs: `i_stall = inst_en & ~i_done` and `d_stall = data_en & ~d_done`. Both are combinational from registers and inputs only, with no path from bus inputs.
- Instruction requests always have `bus_wr`=0 and `bus_strb`=0.
- For data requests, `bus_wr` = |`data_sel`.
- `bus_addr` is the translated address, latched at the IDLE decision.
- Reset values: state IDLE, `bus_req` 0, `bus_wr` 0, `bus_strb` 0, `bus_addr` 0, `bus_wdata` 0, `inst_rdata` 0, `data_rdata` 0, done flags 0.
  - Because done flags reset to 0, `i_stall`/`d_stall` follow `inst_en`/`data_en`.
  - Reset mid-transaction drops it with no bus completion expected.

## Timing
- Minimum read latency, with `bus_addr_ok` on the first `bus_req` cycle and `bus_data_ok` one cycle later:
  - C0: request seen in IDLE.
  - C1: `bus_req` asserted.
  - C2: data returns.
  - C3: result valid and stall low.
- Same-cycle `bus_addr_ok` and `bus_data_ok` save one cycle.
- Back-to-back requests: at least one IDLE cycle between transactions.
- Both ports requesting: data completes first; the instruction request issues on the next IDLE cycle.
- `bus_req` and its fields are held constant until `bus_addr_ok`.

## Structure
- Package `mem_arb_pkg` contains:
  - the state enum;
  - the `KSEG0_BASE` (0x8000_0000) and `KSEG2_BASE` (0xC000_0000) constants;
  - the `PHYS_MASK` (0x1FFF_FFFF) constant.
- Sub-module `addr_xlate`: a combinational translator, instantiated once on the IDLE-selected address.

## Test plan
- Fetch only:
  - Stimulus: `inst_addr`=0xBFC0_0000; the bus returns 0x2408_0001 one cycle after `bus_addr_ok`.
  - Required: `bus_addr`=0x1FC0_0000, `bus_wr`=0, `inst_rdata`=0x2408_0001, `i_stall` falls at C3.
- Simultaneous requests:
  - Stimulus: fetch plus load from 0x8000_0010 in the same cycle.
  - Required: the data transaction (`bus_addr` 0x0000_0010) is issued first; `d_stall` falls before `i_stall`.
- Store:
  - Stimulus: `data_sel`=4'b0011, `data_wdata`=0x1234_ABCD.
  - Required: `bus_wr`=1, `bus_strb`=0011, `data_rdata` unchanged.
- Frozen pipeline:
  - Stimulus: fetch completes while `longest_stall` stays high for 5 cycles because of the data port.
  - Required: no second fetch is issued, and `inst_rdata` is held for those 5 cycles.
- Exception flush:
  - Stimulus: `inst_en` drops during IWAIT.
  - Required: the transaction completes, `i_stall`=0 immediately, and the state returns to IDLE.
- Async reset:
  - Stimulus: `resetn` asserted during DWAIT.
  - Required: state is IDLE and `bus_req`=0 in the same cycle, and all outputs take their reset values.
